// File: rtl/scalar_pkg.sv
// scalar_pkg: shared widths, writeback entry and round-robin source types
package scalar_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  typedef struct packed {
    logic [ADDR_W-1:0] dir;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  typedef enum logic {SRC_MEM, SRC_ALU} src_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous DEPTH-entry FIFO with occupancy count
module wb_fifo #(
  parameter int W = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/scalar_writeback_unit.sv
// scalar_writeback_unit: arbitrates ALU/load results into a FIFO feeding the
// scalar register bank write port, with a per-register pending scoreboard.
module scalar_writeback_unit
  import scalar_pkg::*;
#(
  parameter int DATA_W = scalar_pkg::DATA_W,
  parameter int ADDR_W = scalar_pkg::ADDR_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dir,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_dir,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_dir,
  input  logic                     esc_hold,
  output logic [ADDR_W-1:0]        dir_esc,
  output logic [DATA_W-1:0]        data,
  output logic                     signal_esc,
  output logic [2**ADDR_W-1:0]     pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_unclaimed
);
  localparam int NR = 2**ADDR_W;
  src_t rr;
  logic full, empty, push, pop;
  wb_entry_t din, head;
  logic [NR-1:0] set_m, clr_m;
  assign alu_ready = !full && alu_valid && (!mem_valid || rr == SRC_ALU);
  assign mem_ready = !full && mem_valid && (!alu_valid || rr == SRC_MEM);
  assign push = alu_ready || mem_ready;
  assign pop = !empty && !esc_hold;
  assign din = alu_ready ? '{dir: alu_dir, data: alu_data} : '{dir: mem_dir, data: mem_data};
  // clear is applied before set so a same-cycle reclaim stays pending
  assign set_m = claim_valid ? NR'(1) << claim_dir : '0;
  assign clr_m = pop ? NR'(1) << head.dir : '0;
  wb_fifo #(.W($bits(wb_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr <= SRC_MEM;
      dir_esc <= '0;
      data <= '0;
      signal_esc <= 1'b0;
      pending <= '0;
      err_unclaimed <= 1'b0;
    end else begin
      if (push && alu_valid && mem_valid) rr <= (rr == SRC_MEM) ? SRC_ALU : SRC_MEM;
      if (pop) begin
        dir_esc <= head.dir;
        data <= head.data;
      end
      signal_esc <= pop;
      pending <= (pending & ~clr_m) | set_m;
      if (pop && !pending[head.dir]) err_unclaimed <= 1'b1;
    end
endmodule

// File: tb/tb_scalar_writeback_unit.sv
// tb_scalar_writeback_unit: table-driven directed checks plus async-reset and
// post-reset arbitration sequences.
module tb_scalar_writeback_unit;
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, mem_valid = 0, claim_valid = 0, esc_hold = 0;
  logic [2:0] alu_dir = 0, mem_dir = 0, claim_dir = 0;
  logic [7:0] alu_data = 0, mem_data = 0;
  logic alu_ready, mem_ready, signal_esc, err_unclaimed;
  logic [2:0] dir_esc, count;
  logic [7:0] data, pending;
  int checks = 0, failures = 0;

  typedef struct {
    logic av; logic [2:0] ad; logic [7:0] adat;
    logic mv; logic [2:0] md; logic [7:0] mdat;
    logic cv; logic [2:0] cd; logic hold;
    logic e_ar, e_mr;
    logic e_sig; logic [2:0] e_dir; logic [7:0] e_data;
    logic [2:0] e_cnt; logic [7:0] e_pend; logic e_err;
  } vec_t;
  vec_t vecs[$];

  scalar_writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_dir(alu_dir), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dir(mem_dir), .mem_data(mem_data), .mem_ready(mem_ready),
    .claim_valid(claim_valid), .claim_dir(claim_dir), .esc_hold(esc_hold),
    .dir_esc(dir_esc), .data(data), .signal_esc(signal_esc),
    .pending(pending), .count(count), .err_unclaimed(err_unclaimed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int i, input vec_t v);
    @(negedge clk);
    alu_valid = v.av; alu_dir = v.ad; alu_data = v.adat;
    mem_valid = v.mv; mem_dir = v.md; mem_data = v.mdat;
    claim_valid = v.cv; claim_dir = v.cd; esc_hold = v.hold;
    #1;
    chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(v.e_ar));
    chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(v.e_mr));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.signal_esc", i), 32'(signal_esc), 32'(v.e_sig));
    chk($sformatf("v%0d.dir_esc", i), 32'(dir_esc), 32'(v.e_dir));
    chk($sformatf("v%0d.data", i), 32'(data), 32'(v.e_data));
    chk($sformatf("v%0d.count", i), 32'(count), 32'(v.e_cnt));
    chk($sformatf("v%0d.pending", i), 32'(pending), 32'(v.e_pend));
    chk($sformatf("v%0d.err", i), 32'(err_unclaimed), 32'(v.e_err));
  endtask

  initial begin
    // single write to claimed r5
    vecs.push_back('{0,0,0, 0,0,0, 1,5,0, 0,0, 0,0,8'h00,0,8'h20,0});
    vecs.push_back('{1,5,8'h3C, 0,0,0, 0,0,0, 1,0, 0,0,8'h00,1,8'h20,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 1,5,8'h3C,0,8'h00,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 0,5,8'h3C,0,8'h00,0});
    // contention: claims then mem wins first, alu second
    vecs.push_back('{0,0,0, 0,0,0, 1,2,0, 0,0, 0,5,8'h3C,0,8'h04,0});
    vecs.push_back('{0,0,0, 0,0,0, 1,1,0, 0,0, 0,5,8'h3C,0,8'h06,0});
    vecs.push_back('{0,0,0, 0,0,0, 1,4,0, 0,0, 0,5,8'h3C,0,8'h16,0});
    vecs.push_back('{1,1,8'h11, 1,2,8'h22, 0,0,0, 0,1, 0,5,8'h3C,1,8'h16,0});
    vecs.push_back('{1,1,8'h11, 1,4,8'h44, 0,0,0, 1,0, 1,2,8'h22,1,8'h12,0});
    vecs.push_back('{0,0,0, 1,4,8'h44, 0,0,0, 0,1, 1,1,8'h11,1,8'h10,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 1,4,8'h44,0,8'h00,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 0,4,8'h44,0,8'h00,0});
    // backpressure: fill to 4, alu r3 stalls while full, then drain in order
    vecs.push_back('{1,0,8'h01, 0,0,0, 1,0,1, 1,0, 0,4,8'h44,1,8'h01,0});
    vecs.push_back('{0,0,0, 1,6,8'h06, 1,6,1, 0,1, 0,4,8'h44,2,8'h41,0});
    vecs.push_back('{1,1,8'h0A, 0,0,0, 1,1,1, 1,0, 0,4,8'h44,3,8'h43,0});
    vecs.push_back('{0,0,0, 1,2,8'h0B, 1,2,1, 0,1, 0,4,8'h44,4,8'h47,0});
    vecs.push_back('{1,3,8'h33, 0,0,0, 1,3,1, 0,0, 0,4,8'h44,4,8'h4F,0});
    vecs.push_back('{1,3,8'h33, 0,0,0, 0,0,0, 0,0, 1,0,8'h01,3,8'h4E,0});
    vecs.push_back('{1,3,8'h33, 0,0,0, 0,0,0, 1,0, 1,6,8'h06,3,8'h0E,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 1,1,8'h0A,2,8'h0C,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 1,2,8'h0B,1,8'h08,0});
    // r3 issues while reclaimed: set wins
    vecs.push_back('{0,0,0, 0,0,0, 1,3,0, 0,0, 1,3,8'h33,0,8'h08,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 0,3,8'h33,0,8'h08,0});
    // unclaimed write to r7 sets sticky error
    vecs.push_back('{0,0,0, 1,7,8'h77, 0,0,0, 0,1, 0,3,8'h33,1,8'h08,0});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 1,7,8'h77,0,8'h08,1});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 0,7,8'h77,0,8'h08,1});
    // queue 4, release one cycle before the async reset
    vecs.push_back('{1,0,8'hC0, 0,0,0, 1,0,1, 1,0, 0,7,8'h77,1,8'h09,1});
    vecs.push_back('{1,1,8'hC1, 0,0,0, 1,1,1, 1,0, 0,7,8'h77,2,8'h0B,1});
    vecs.push_back('{1,2,8'hC2, 0,0,0, 1,2,1, 1,0, 0,7,8'h77,3,8'h0F,1});
    vecs.push_back('{1,4,8'hC3, 0,0,0, 1,4,1, 1,0, 0,7,8'h77,4,8'h1F,1});
    vecs.push_back('{0,0,0, 0,0,0, 0,0,0, 0,0, 1,0,8'hC0,3,8'h1E,1});

    repeat (2) @(posedge clk);
    #1;
    chk("rst.signal_esc", 32'(signal_esc), 0);
    chk("rst.dir_esc", 32'(dir_esc), 0);
    chk("rst.data", 32'(data), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.pending", 32'(pending), 0);
    chk("rst.err", 32'(err_unclaimed), 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) step(i, vecs[i]);

    // async reset between edges with 3 entries queued and a write in flight
    #2 rst_n = 0;
    #1;
    chk("arst.signal_esc", 32'(signal_esc), 0);
    chk("arst.count", 32'(count), 0);
    chk("arst.pending", 32'(pending), 0);
    chk("arst.err", 32'(err_unclaimed), 0);
    #1 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("arst.idle%0d.signal_esc", k), 32'(signal_esc), 0);
      chk($sformatf("arst.idle%0d.count", k), 32'(count), 0);
    end

    // pointer back at mem after reset
    @(negedge clk);
    alu_valid = 1; alu_dir = 1; alu_data = 8'h5A;
    mem_valid = 1; mem_dir = 2; mem_data = 8'hA5;
    #1;
    chk("rr.mem_ready", 32'(mem_ready), 1);
    chk("rr.alu_ready", 32'(alu_ready), 0);
    @(negedge clk);
    mem_valid = 0;
    #1;
    chk("rr.alu_ready2", 32'(alu_ready), 1);
    @(negedge clk);
    alu_valid = 0;
    #1;
    chk("rr.first_dir", 32'(dir_esc), 2);
    chk("rr.first_data", 32'(data), 32'h A5);
    @(posedge clk);
    #1;
    chk("rr.second_dir", 32'(dir_esc), 1);
    chk("rr.second_data", 32'(data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
